// File: rtl/uart_demo_pkg.sv
// Shared constants for the auto-send UART demo: message contents, 8N1 frame
// layout and the sequencer state type.
package uart_demo_pkg;

    localparam int MSG_LEN = 7;
    localparam logic [7:0] MSG [MSG_LEN] = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F, 8'h0D, 8'h0A};

    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam int   DATA_BITS  = 8;
    localparam int   FRAME_BITS = DATA_BITS + 2;

    typedef enum logic [1:0] {
        WAIT,
        SEND,
        BUSY,
        GAP
    } seq_state_e;

endpackage

// File: rtl/uart_tx.sv
// UART 8N1 transmitter: shifts out one 10-bit frame per accepted tx_start,
// each bit held for CLK_FREQ/BAUD clocks, with a registered serial output.
`timescale 1ns/1ps
module uart_tx
    import uart_demo_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 115_200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       uart_txd,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam int BIT_CYCLES = CLK_FREQ / BAUD;
    localparam int BAUD_W     = $clog2(BIT_CYCLES) + 1;
    localparam int IDX_W      = $clog2(FRAME_BITS) + 1;

    logic [BAUD_W-1:0]     baud_cnt_q, baud_cnt_d;
    logic [IDX_W-1:0]      bit_idx_q, bit_idx_d;
    logic [FRAME_BITS-1:0] frame_q, frame_d;
    logic                  txd_q, txd_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        baud_cnt_d = baud_cnt_q;
        bit_idx_d  = bit_idx_q;
        frame_d    = frame_q;
        txd_d      = txd_q;
        busy_d     = busy_q;
        done_d     = 1'b0;

        if (!busy_q) begin
            if (tx_start) begin
                frame_d    = {STOP_BIT, tx_data, START_BIT};
                txd_d      = START_BIT;
                busy_d     = 1'b1;
                baud_cnt_d = '0;
                bit_idx_d  = '0;
            end
        end else if (baud_cnt_q == BAUD_W'(BIT_CYCLES - 1)) begin
            baud_cnt_d = '0;
            if (bit_idx_q == IDX_W'(FRAME_BITS - 1)) begin
                bit_idx_d = '0;
                busy_d    = 1'b0;
                done_d    = 1'b1;
                txd_d     = 1'b1;
            end else begin
                // The frame shifts right so bit 1 is always the next bit to drive.
                bit_idx_d = bit_idx_q + 1'b1;
                txd_d     = frame_q[1];
                frame_d   = {1'b1, frame_q[FRAME_BITS-1:1]};
            end
        end else begin
            baud_cnt_d = baud_cnt_q + 1'b1;
        end
    end

    // rst_n is active-high on this board despite its name.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            baud_cnt_q <= '0;
            bit_idx_q  <= '0;
            frame_q    <= '1;
            txd_q      <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            baud_cnt_q <= baud_cnt_d;
            bit_idx_q  <= bit_idx_d;
            frame_q    <= frame_d;
            txd_q      <= txd_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign uart_txd = txd_q;
    assign tx_busy  = busy_q;
    assign tx_done  = done_q;

endmodule

// File: rtl/top_auto_send.sv
// Self-running UART demo: waits START_DELAY cycles after reset, then sends the
// fixed message forever with GAP_CYCLES of idle line between repetitions.
`timescale 1ns/1ps
module top_auto_send
    import uart_demo_pkg::*;
#(
    parameter int CLK_FREQ    = 50_000_000,
    parameter int BAUD        = 115_200,
    parameter int START_DELAY = 1_000,
    parameter int GAP_CYCLES  = 50_000
) (
    input  logic clk,
    input  logic rst_n,
    output logic uart_txd
);

    localparam int CNT_MAX = (START_DELAY > GAP_CYCLES) ? START_DELAY : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;
    localparam int IDX_W   = $clog2(MSG_LEN) + 1;

    seq_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_busy;
    logic       tx_done;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        tx_start = 1'b0;

        tx_data = '0;
        for (int i = 0; i < MSG_LEN; i++) begin
            if (idx_q == IDX_W'(i)) tx_data = MSG[i];
        end

        unique case (state_q)
            WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(START_DELAY - 1)) begin
                    cnt_d   = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                tx_start = !tx_busy;
                if (!tx_busy) state_d = BUSY;
            end
            BUSY: begin
                if (tx_done) begin
                    if (idx_q == IDX_W'(MSG_LEN - 1)) begin
                        idx_d   = '0;
                        cnt_d   = '0;
                        state_d = GAP;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = SEND;
                    end
                end
            end
            GAP: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = SEND;
                end
            end
            default: state_d = WAIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q <= WAIT;
            cnt_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
        end
    end

    uart_tx #(
        .CLK_FREQ(CLK_FREQ),
        .BAUD    (BAUD)
    ) u_uart_tx (
        .clk     (clk),
        .rst_n   (rst_n),
        .tx_start(tx_start),
        .tx_data (tx_data),
        .uart_txd(uart_txd),
        .tx_busy (tx_busy),
        .tx_done (tx_done)
    );

endmodule

// File: tb/tb_top_auto_send.sv
// Bench for top_auto_send: a UART monitor decodes the serial line and checks each
// frame and its preceding idle time against a scoreboard of expected bytes.
`timescale 1ns/1ps
module tb_top_auto_send;

    localparam int BC          = 4;
    localparam int START_DELAY = 10;
    localparam int GAP_CYCLES  = 20;
    localparam int FRAME_CYC   = 10 * BC;
    localparam int DFLT_BIT    = 50_000_000 / 115_200;
    localparam int CLK_NS      = 20;

    typedef struct {
        logic [7:0] data;
        int         min_idle;
        int         max_idle;
    } exp_t;

    logic [7:0] msg_ref [7] = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F, 8'h0D, 8'h0A};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst2 = 1'b1;
    logic txd, txd2;

    exp_t sb_q [$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   frames_started = 0;
    int   frames_done = 0;
    bit   mon_en = 1'b1;
    bit   dflt_done = 1'b0;

    always #(CLK_NS / 2) clk = ~clk;

    top_auto_send #(
        .CLK_FREQ   (50_000_000),
        .BAUD       (12_500_000),
        .START_DELAY(START_DELAY),
        .GAP_CYCLES (GAP_CYCLES)
    ) dut (
        .clk     (clk),
        .rst_n   (rst),
        .uart_txd(txd)
    );

    top_auto_send dut_dflt (
        .clk     (clk),
        .rst_n   (rst2),
        .uart_txd(txd2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_checks++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d..%0d (t=%0t)", name, act, lo, hi, $time);
        end
    endtask

    // Reference model: message n follows START_DELAY after reset, later ones GAP_CYCLES
    // after the previous LF; bytes inside a message are back to back (2-cycle handshake).
    task automatic push_msgs(input int n_msgs);
        exp_t e;
        for (int m = 0; m < n_msgs; m++) begin
            for (int i = 0; i < 7; i++) begin
                e.data = msg_ref[i];
                if (m == 0 && i == 0) begin
                    e.min_idle = START_DELAY; e.max_idle = START_DELAY + 2;
                end else if (i == 0) begin
                    e.min_idle = GAP_CYCLES;  e.max_idle = GAP_CYCLES + 2;
                end else begin
                    e.min_idle = 0;           e.max_idle = 2;
                end
                sb_q.push_back(e);
            end
        end
    endtask

    function automatic int low_run(input logic [7:0] d);
        logic [9:0] f;
        int n;
        f = {1'b1, d, 1'b0};
        n = 0;
        while (n < 10 && f[n] == 1'b0) n++;
        return n;
    endfunction

    // Monitor: decodes frames from the serial line and scores them.
    logic       s [FRAME_CYC];
    logic [9:0] bits;
    bit         aborted, uniform;
    int         idle;
    exp_t       e_mon;

    initial begin : monitor
        idle = 0;
        forever begin
            @(negedge clk);
            if (rst || !mon_en) begin
                idle = 0;
            end else if (txd === 1'b1) begin
                idle++;
            end else begin
                frames_started++;
                s[0] = txd;
                aborted = 1'b0;
                for (int i = 1; i < FRAME_CYC; i++) begin
                    @(negedge clk);
                    if (rst) begin
                        aborted = 1'b1;
                        break;
                    end
                    s[i] = txd;
                end
                if (!aborted) begin
                    for (int k = 0; k < 10; k++) bits[k] = s[k * BC + BC / 2];
                    uniform = 1'b1;
                    for (int i = 0; i < FRAME_CYC; i++)
                        if (s[i] !== bits[i / BC]) uniform = 1'b0;
                    check("sb_pending", 32'(sb_q.size() > 0), 1);
                    if (sb_q.size() > 0) begin
                        e_mon = sb_q.pop_front();
                        check_range("idle_before_frame", idle, e_mon.min_idle, e_mon.max_idle);
                        check("frame_bits", 32'(bits), 32'({1'b1, e_mon.data, 1'b0}));
                        check("rx_byte", 32'(bits[8:1]), 32'(e_mon.data));
                        check("bit_width", 32'(uniform), 1);
                    end
                    frames_done++;
                end
                idle = 0;
            end
        end
    end

    // Default-parameter instance: measure the bit period from the first frame's low run.
    initial begin : dflt_measure
        time t_fall, t_rise;
        int  low_cyc, budget;
        budget = 0;
        @(negedge clk);
        while (txd2 !== 1'b0 && budget < 3000) begin
            @(negedge clk);
            budget++;
        end
        check("dflt_first_start_seen", 32'(txd2 === 1'b0), 1);
        t_fall = $time;
        low_cyc = 0;
        while (txd2 === 1'b0 && low_cyc < 4000) begin
            @(negedge clk);
            low_cyc++;
        end
        t_rise = $time;
        check("dflt_low_cycles", 32'(low_cyc), 32'(low_run(msg_ref[0]) * DFLT_BIT));
        check("dflt_start_bit_ns", 32'((t_rise - t_fall) / low_run(msg_ref[0])), 32'(DFLT_BIT * CLK_NS));
        dflt_done = 1'b1;
    end

    initial begin : main
        int cyc;
        rst  = 1'b1;
        rst2 = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("reset_txd", 32'(txd), 1);
            check("reset_txd_dflt", 32'(txd2), 1);
        end

        push_msgs(3);
        @(posedge clk);
        #1;
        rst  = 1'b0;
        rst2 = 1'b0;

        cyc = 0;
        while (frames_started < 17 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        check("third_msg_third_byte_started", 32'(frames_started >= 17), 1);

        repeat (15) @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("txd_high_after_mid_reset", 32'(txd), 1);
        check("frames_before_reset", 32'(frames_done), 16);

        sb_q.delete();
        push_msgs(1);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        cyc = 0;
        while (frames_done < 23 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        check("msg_after_reset_done", 32'(frames_done), 23);
        mon_en = 1'b0;

        cyc = 0;
        while (!dflt_done && cyc < 5000) begin
            @(negedge clk);
            cyc++;
        end
        check("dflt_measure_done", 32'(dflt_done), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
